// File: rtl/alu_pkg.sv
// Shared ALU opcodes, checker state encoding and MISR constants.
// Also holds the expectation bundle carried through the latency pipe.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } chk_state_t;

  typedef struct packed {
    logic [31:0] r;
    logic        zero;
    logic        ovf;
    logic        branch;
  } alu_res_t;

  typedef struct packed {
    logic     valid;
    alu_res_t res;
  } exp_t;

  function automatic logic [31:0] misr_step(
    input logic [31:0] sig,
    input logic [31:0] din
  );
    logic [31:0] fb;
    fb = sig[31] ? MISR_POLY : 32'h0;
    return ({sig[30:0], 1'b0} ^ fb) ^ din;
  endfunction

endpackage

// File: rtl/alu_resp_checker_if.sv
// ALU operand stream plus the ALU's observed response.
// master drives it (stimulus + ALU), slave snoops it (checker).
interface alu_resp_checker_if;

  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_ctrl;
  logic [31:0] obs_r;
  logic        obs_zero;
  logic        obs_ovf;
  logic        obs_branch;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_ctrl,
    output obs_r,
    output obs_zero,
    output obs_ovf,
    output obs_branch
  );

  modport slave (
    input in_valid,
    input in_a,
    input in_b,
    input in_ctrl,
    input obs_r,
    input obs_zero,
    input obs_ovf,
    input obs_branch
  );

endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: ADD/SUB/AND/OR with zero, ovf, branch.
// Arithmetic is modulo 2^32; ovf is signed overflow.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  ctrl,
  output logic [31:0] r,
  output logic        zero,
  output logic        ovf,
  output logic        branch
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;

  assign sum  = a + b;
  assign diff = a - b;

  assign add_ovf = (a[31] == b[31])
                 & (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31])
                 & (diff[31] != a[31]);

  always_comb begin
    r   = sum;
    ovf = 1'b0;
    unique case (1'b1)
      (ctrl == ALU_ADD): begin
        r   = sum;
        ovf = add_ovf;
      end
      (ctrl == ALU_SUB): begin
        r   = diff;
        ovf = sub_ovf;
      end
      (ctrl == ALU_AND): r = a & b;
      (ctrl == ALU_OR):  r = a | b;
    endcase
  end

  assign zero   = (r == 32'h0);
  assign branch = (ctrl == ALU_SUB) & zero;

endmodule

// File: rtl/alu_resp_checker.sv
// ALU response checker: reference model, latency-matched compare,
// error tally, first-failure index and MISR over observed results.
module alu_resp_checker
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  alu_resp_checker_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [31:0]      signature
);

  chk_state_t       state;
  chk_state_t       state_nx;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] issued_nx;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] err_nx;
  exp_t             pipe [ALU_LAT];
  exp_t             head;
  alu_res_t         exp_now;
  alu_res_t         obs;
  logic             push;
  logic             cmp;
  logic             mism;
  logic             tail_live;
  logic             clr;

  alu_ref_model u_ref (
    .a      (bus.in_a),
    .b      (bus.in_b),
    .ctrl   (bus.in_ctrl),
    .r      (exp_now.r),
    .zero   (exp_now.zero),
    .ovf    (exp_now.ovf),
    .branch (exp_now.branch)
  );

  assign head = pipe[ALU_LAT-1];
  assign obs  = '{r:      bus.obs_r,
                  zero:   bus.obs_zero,
                  ovf:    bus.obs_ovf,
                  branch: bus.obs_branch};

  assign push = (state == ST_RUN)
              & bus.in_valid
              & (issued != limit);
  assign issued_nx = issued + CNT_W'(push);

  assign cmp  = head.valid;
  assign mism = cmp & (head.res != obs);

  assign err_nx = (mism && err_count != '1)
                ? err_count + 1'b1
                : err_count;

  assign clr = start
             & ((state == ST_IDLE) | (state == ST_DONE));

  // Entries still travelling behind the head keep DRAIN alive.
  always_comb begin
    tail_live = 1'b0;
    for (int i = 0; i < ALU_LAT - 1; i++)
      tail_live = tail_live | pipe[i].valid;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN:   if (issued_nx == limit)
                  state_nx = ST_DRAIN;
      ST_DRAIN: if (!tail_live) state_nx = ST_DONE;
      ST_DONE:  if (start) state_nx = ST_RUN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      issued        <= '0;
      limit         <= '0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '1;
      signature     <= MISR_SEED;
      for (int i = 0; i < ALU_LAT; i++)
        pipe[i] <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == ST_RUN)
             | (state_nx == ST_DRAIN);
      done  <= (state_nx == ST_DONE);
      pass  <= (state_nx == ST_DONE)
             & (err_nx == '0);
      if (clr) begin
        issued        <= '0;
        limit         <= target;
        vec_count     <= '0;
        err_count     <= '0;
        first_err_idx <= '1;
        signature     <= MISR_SEED;
        for (int i = 0; i < ALU_LAT; i++)
          pipe[i] <= '0;
      end else begin
        issued  <= issued_nx;
        pipe[0] <= '{valid: push, res: exp_now};
        for (int i = 1; i < ALU_LAT; i++)
          pipe[i] <= pipe[i-1];
        if (cmp) begin
          vec_count <= vec_count + 1'b1;
          err_count <= err_nx;
          signature <= misr_step(signature,
                                 bus.obs_r);
          if (mism && err_count == '0)
            first_err_idx <= vec_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed bench for alu_resp_checker with ALU_LAT=1.
// Observed ALU results are hand-computed and fed one cycle late.
module tb_alu_resp_checker;
  import alu_pkg::*;

  localparam int LAT = 1;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] target;
  logic          busy, done, pass;
  logic [CW-1:0] vec_count, err_count, first_err_idx;
  logic [31:0]   signature;

  int errors = 0;
  int checks = 0;

  logic [31:0] p_r;
  logic        p_z, p_o, p_b;

  alu_resp_checker_if bus ();

  alu_resp_checker #(.ALU_LAT(LAT), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .target        (target),
    .bus           (bus.slave),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .vec_count     (vec_count),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .signature     (signature)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a vector now; present the previous vector's result too.
  task automatic drive(input logic v,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [1:0] c,
                       input logic [31:0] r,
                       input logic z, input logic o,
                       input logic br);
    bus.in_valid   = v;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_ctrl    = c;
    bus.obs_r      = p_r;
    bus.obs_zero   = p_z;
    bus.obs_ovf    = p_o;
    bus.obs_branch = p_b;
    p_r = r; p_z = z; p_o = o; p_b = br;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic begin_session(input logic [CW-1:0] t);
    start  = 1'b1;
    target = t;
    idle();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      idle();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    target = '0;
    p_r = '0; p_z = 0; p_o = 0; p_b = 0;
    idle();
    idle();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_vec", 32'(vec_count), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_fei", 32'(first_err_idx), 32'h0000_FFFF);
    chk("rst_sig", signature, 32'hFFFF_FFFF);

    // ADD 7+5
    begin_session(16'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    drive(1, 32'd7, 32'd5, ALU_ADD, 32'd12, 0, 0, 0);
    wait_done("t1_done", 10);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_vec", 32'(vec_count), 32'd1);
    chk("t1_err", 32'(err_count), 32'd0);
    chk("t1_fei", 32'(first_err_idx), 32'h0000_FFFF);
    chk("t1_sig", signature, 32'hFB3E_E245);
    chk("t1_busy0", 32'(busy), 32'd0);

    // signed overflow both directions
    begin_session(16'd2);
    drive(1, 32'h7FFF_FFFF, 32'd1, ALU_ADD,
          32'h8000_0000, 0, 1, 0);
    drive(1, 32'h8000_0000, 32'd1, ALU_SUB,
          32'h7FFF_FFFF, 0, 1, 0);
    wait_done("t2_done", 10);
    chk("t2_pass", 32'(pass), 32'd1);
    chk("t2_vec", 32'(vec_count), 32'd2);

    // zero / branch
    begin_session(16'd2);
    drive(1, 32'd5, 32'd5, ALU_SUB, 32'd0, 1, 0, 1);
    drive(1, 32'hF0, 32'h0F, ALU_AND, 32'd0, 1, 0, 0);
    wait_done("t3_done", 10);
    chk("t3_pass", 32'(pass), 32'd1);
    chk("t3_vec", 32'(vec_count), 32'd2);

    // vector 3 corrupted; bubble and ignored start mid-run
    begin_session(16'd5);
    drive(1, 32'd1, 32'd2, ALU_OR, 32'd3, 0, 0, 0);
    drive(1, 32'd10, 32'd20, ALU_ADD, 32'd30, 0, 0, 0);
    start = 1'b1;
    target = 16'd1;
    idle();
    start = 1'b0;
    drive(1, 32'd3, 32'd5, ALU_SUB,
          32'hFFFF_FFFE, 0, 0, 0);
    drive(1, 32'hFFFF_0000, 32'h0F0F_0F0F, ALU_AND,
          32'h0F0F_0001, 0, 0, 0);
    drive(1, 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0, 1, 0, 0);
    wait_done("t4_done", 10);
    chk("t4_err", 32'(err_count), 32'd1);
    chk("t4_fei", 32'(first_err_idx), 32'd3);
    chk("t4_pass", 32'(pass), 32'd0);
    chk("t4_vec", 32'(vec_count), 32'd5);

    // reset mid-run
    begin_session(16'd10);
    drive(1, 32'd0, 32'd100, ALU_ADD, 32'd100, 0, 0, 0);
    drive(1, 32'd1, 32'd100, ALU_ADD, 32'd101, 0, 0, 0);
    reset = 1'b1;
    drive(1, 32'd2, 32'd100, ALU_ADD, 32'd102, 0, 0, 0);
    reset = 1'b0;
    p_r = '0; p_z = 0; p_o = 0; p_b = 0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_vec", 32'(vec_count), 32'd0);
    chk("t5_err", 32'(err_count), 32'd0);
    chk("t5_sig", signature, 32'hFFFF_FFFF);
    idle();
    begin_session(16'd10);
    for (int i = 0; i < 10; i++)
      drive(1, 32'(i), 32'd100, ALU_ADD,
            32'(i + 100), 0, 0, 0);
    wait_done("t5_done", 10);
    chk("t5_pass", 32'(pass), 32'd1);
    chk("t5_vec10", 32'(vec_count), 32'd10);

    // empty session
    begin_session(16'd0);
    wait_done("t6_done", LAT + 1);
    chk("t6_vec", 32'(vec_count), 32'd0);
    chk("t6_pass", 32'(pass), 32'd1);
    chk("t6_sig", signature, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_resp_checker.md
Name: alu_resp_checker

Overview:
- Response side of the ALU verification loop; it is the consumer end of the ALU interface, while the stimulus generator is the producer.
- It snoops the same operand stream driven into the ALU and computes expected results with an internal reference model.
- It delays those expectations to match ALU latency, then compares them against the observed R/zero/ovf/branch.
- It accumulates a pass/fail verdict, an error count, the first failing index and a MISR signature, and is synthesizable so it can run on-chip as self-test.

Parameters:
- ALU_LAT, 1, ALU operand-to-result latency in cycles (must be >= 1).
- CNT_W, 16, width of the vector, error and index counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a session (from IDLE or DONE).
- target  in  CNT_W  number of vectors in the session; sampled on start.
- in_valid  in  1  operand vector is being presented to the ALU this cycle.
- in_a  in  32  operand A as driven to the ALU.
- in_b  in  32  operand B as driven to the ALU.
- in_ctrl  in  2  ALU CTRL as driven to the ALU.
- obs_r  in  32  ALU R output.
- obs_zero  in  1  ALU zero output.
- obs_ovf  in  1  ALU ovf output.
- obs_branch  in  1  ALU branch output.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- pass  out  1  done and err_count==0.
- vec_count  out  CNT_W  vectors compared so far.
- err_count  out  CNT_W  mismatching vectors; saturates at all-ones.
- first_err_idx  out  CNT_W  0-based index of the first mismatch; all-ones if none.
- signature  out  32  MISR over compared obs_r values.

Behaviour:
- Reset (any state, including mid-session): state=IDLE, pipeline valid bits=0, all counters=0, first_err_idx=all-ones, signature=32'hFFFF_FFFF, busy=done=pass=0.
- Reference model, per CTRL:
  - 00 ADD: R=A+B; ovf = signed overflow (operand signs equal, result sign differs).
  - 01 SUB: R=A-B; ovf = signed overflow (operand signs differ, result sign differs from A).
  - 10 AND: R=A&B; ovf=0.
  - 11 OR: R=A|B; ovf=0.
  - zero = (R==0) for all ops.
  - branch = (CTRL==SUB) & zero.
  - All arithmetic is modulo 2^32.
- FSM states are IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start:
  - Clears counters, the pipeline and first_err_idx.
  - Loads the signature seed 32'hFFFF_FFFF.
  - Latches target into an internal issued-count limit.
- RUN:
  - Each cycle with in_valid=1 and issued<target pushes {expected, valid=1} into an ALU_LAT-deep shift pipeline and increments issued.
  - in_valid with issued==target is ignored.
  - A cycle without in_valid pushes valid=0 (bubble).
  - RUN -> DRAIN in the cycle issued reaches target.
  - target=0 goes RUN -> DRAIN in the first RUN cycle.
- DRAIN: pushes bubbles; DRAIN -> DONE once no valid bits remain in the pipeline.
- Comparison is made whenever the pipeline output entry is valid, in any state, using that cycle's obs_* values:
  - vec_count increments.
  - Mismatch = any of R/zero/ovf/branch differs.
  - On mismatch, err_count increments, saturating.
  - On the first mismatch, first_err_idx takes the pre-increment vec_count.
  - signature <= ({sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0)) ^ obs_r.
- DONE:
  - Holds all results.
  - start re-enters RUN with the same clearing as IDLE -> RUN.
- start during RUN or DRAIN is ignored.
- Latency: expectation for a vector accepted at cycle t is compared at cycle t+ALU_LAT.
- Outputs are registered; done asserts the cycle after the last valid entry leaves the pipeline.

Decomposition:
- Package alu_pkg holds:
  - CTRL opcode constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - Checker state encoding.
  - MISR polynomial constant 32'h04C11DB7 and seed 32'hFFFF_FFFF.
- Sub-module alu_ref_model: combinational A, B, CTRL -> R, zero, ovf, branch. It is also reusable by other benches.

Test Plan:
- ADD 7+5, target=1, correct ALU -> obs R=12, zero=0, ovf=0; done, pass=1, vec_count=1, err_count=0, first_err_idx=16'hFFFF.
- ADD 0x7FFF_FFFF+1 then SUB 0x8000_0000-1 -> expected R=0x8000_0000, ovf=1 and R=0x7FFF_FFFF, ovf=1; pass=1.
- SUB 5-5 then AND 0xF0&0x0F, target=2 -> first zero=1, branch=1; second R=0, zero=1, branch=0; pass=1.
- target=5 with obs_r forced wrong (XOR 1) on vector 3 only -> err_count=1, first_err_idx=3, pass=0, vec_count=5.
- reset asserted mid-RUN after 2 of 10 vectors -> next cycle IDLE, busy=0, counters=0, signature=32'hFFFF_FFFF; following start and 10 vectors completes with pass=1.
- target=0 start -> done within ALU_LAT+2 cycles, vec_count=0, pass=1, signature=32'hFFFF_FFFF.
